// File: rtl/cla_seq_addsub_ov_if.sv
// Operand/result bus for the sequential add/subtract unit.
// Handshake: the master raises start with op/a/b/ci valid; the unit takes
// them on a rising edge whenever busy is low (IDLE or DONE) and ignores start
// while busy is high. done pulses for one cycle when s and the flags hold a
// new result. There is no backpressure: the master must accept that result
// in the done cycle, and s and the flags then hold it until the next completion.
interface cla_seq_addsub_ov_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             co_prev;
  logic             ov;
  logic             zero;
  logic             neg;

  modport master (
    output start, op, a, b, ci,
    input  busy, done, s, co, co_prev, ov, zero, neg
  );

  modport slave (
    input  start, op, a, b, ci,
    output busy, done, s, co, co_prev, ov, zero, neg
  );
endinterface

// File: rtl/cla_seq_addsub_ov.sv
// Multi-cycle add/subtract: one CHUNK-bit carry-lookahead slice per cycle,
// LSB chunk first, with the carry registered between chunks. Produces the
// sum plus carry, carry-into-MSB, signed overflow, zero and negative flags.
module cla_seq_addsub_ov #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  cla_seq_addsub_ov_if.slave    bus,
  output logic [1:0]            o_dbg_state
);
  localparam int NCYC = WIDTH / CHUNK;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_k;

  logic [CHUNK-1:0] w_p;
  logic [CHUNK-1:0] w_g;
  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_sum;
  logic [WIDTH-1:0] w_w_next;

  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_co_prev;
  logic             r_ov;
  logic             r_zero;
  logic             r_neg;

  // New operands are taken whenever the unit is not mid-operation.
  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_k == CW'(NCYC - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; DONE may chain straight into RUN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  w_next_state = bus.start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // CHUNK-bit lookahead slice: every carry is a flat OR of generate terms
  // propagated through the bits above them, seeded by the registered carry.
  always_comb begin
    logic v_term;
    w_p    = r_a[CHUNK-1:0] ^ r_b[CHUNK-1:0];
    w_g    = r_a[CHUNK-1:0] & r_b[CHUNK-1:0];
    w_c    = '0;
    w_c[0] = r_c;
    v_term = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      v_term = r_c;
      for (int k = 0; k <= i; k++) v_term = v_term & w_p[k];
      w_c[i+1] = v_term;
      for (int j = 0; j <= i; j++) begin
        v_term = w_g[j];
        for (int k = j + 1; k <= i; k++) v_term = v_term & w_p[k];
        w_c[i+1] = w_c[i+1] | v_term;
      end
    end
  end

  assign w_sum = w_p ^ w_c[CHUNK-1:0];

  // Working register holds the finished low chunks (oldest at the bottom);
  // the complete result is only formed combinationally on the final chunk.
  generate
    if (NCYC > 1) begin : g_multi
      logic [WIDTH-CHUNK-1:0] r_w;
      // Shift each new chunk sum in from the top.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                 r_w <= '0;
        else if (r_state == S_RUN) r_w <= w_w_next[WIDTH-1:CHUNK];
      end
      assign w_w_next = {w_sum, r_w};
    end else begin : g_single
      assign w_w_next = w_sum;
    end
  endgenerate

  // Operand capture and per-chunk advance: operands shift down so the
  // active chunk is always in the low bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= 1'b0;
      r_k <= '0;
    end else if (w_accept) begin
      r_a <= bus.a;
      r_b <= bus.op ? ~bus.b : bus.b;
      r_c <= bus.ci ^ bus.op;
      r_k <= '0;
    end else if (r_state == S_RUN) begin
      r_a <= r_a >> CHUNK;
      r_b <= r_b >> CHUNK;
      r_c <= w_c[CHUNK];
      r_k <= r_k + 1'b1;
    end
  end

  // Result and flags load only on the edge that finishes the last chunk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s       <= '0;
      r_co      <= 1'b0;
      r_co_prev <= 1'b0;
      r_ov      <= 1'b0;
      r_zero    <= 1'b0;
      r_neg     <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_s       <= w_w_next;
      r_co      <= w_c[CHUNK];
      r_co_prev <= w_c[CHUNK-1];
      r_ov      <= w_c[CHUNK] ^ w_c[CHUNK-1];
      r_zero    <= (w_w_next == '0);
      r_neg     <= w_w_next[WIDTH-1];
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.s       = r_s;
  assign bus.co      = r_co;
  assign bus.co_prev = r_co_prev;
  assign bus.ov      = r_ov;
  assign bus.zero    = r_zero;
  assign bus.neg     = r_neg;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_cla_seq_addsub_ov.sv
// Directed bench for cla_seq_addsub_ov at 64/4, 32/8 and 8/8.
module tb_cla_seq_addsub_ov;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [1:0] dbg64, dbg32, dbg8;

  // clock
  always #5 clk = ~clk;

  cla_seq_addsub_ov_if #(.WIDTH(64)) bus64 ();
  cla_seq_addsub_ov_if #(.WIDTH(32)) bus32 ();
  cla_seq_addsub_ov_if #(.WIDTH(8))  bus8 ();

  cla_seq_addsub_ov #(.WIDTH(64), .CHUNK(4)) dut64 (
    .clk(clk), .reset(reset), .bus(bus64), .o_dbg_state(dbg64));
  cla_seq_addsub_ov #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32), .o_dbg_state(dbg32));
  cla_seq_addsub_ov #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8), .o_dbg_state(dbg8));

  // watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver: start a 64-bit op, wait (bounded) for done; caller sits #1 after an edge
  task automatic go64(input logic op, input logic [63:0] a, input logic [63:0] b,
                      input logic ci, output int lat, output int busy_cnt);
    bus64.op = op; bus64.a = a; bus64.b = b; bus64.ci = ci; bus64.start = 1'b1;
    @(posedge clk); #1;
    bus64.start = 1'b0;
    lat = 0; busy_cnt = 0;
    do begin
      if (bus64.busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end while (bus64.done !== 1'b1 && lat < 100);
    if (bus64.done !== 1'b1) begin
      total++; bad++;
      $display("FAIL go64_timeout: done not seen after %0d edges", lat);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus64.start = 0; bus64.op = 0; bus64.a = '0; bus64.b = '0; bus64.ci = 0;
    bus32.start = 0; bus32.op = 0; bus32.a = '0; bus32.b = '0; bus32.ci = 0;
    bus8.start  = 0; bus8.op  = 0; bus8.a  = '0; bus8.b  = '0; bus8.ci  = 0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus64.busy, bus64.done, bus64.co, bus64.co_prev, bus64.ov, bus64.zero, bus64.neg} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b required 0", {bus64.busy, bus64.done, bus64.co,
                      bus64.co_prev, bus64.ov, bus64.zero, bus64.neg});
    end
    total++;
    if (bus64.s !== 64'h0) begin bad++; $display("FAIL reset_s: got %h required 0", bus64.s); end
    total++;
    if (dbg64 !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d required 0", dbg64); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (bus64.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b required 0", bus64.busy); end
    end
  endtask

  task automatic test_overflow;
    int lat, bc;
    go64(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat, bc);
    total++;
    if (lat !== 16) begin bad++; $display("FAIL ovf_latency: got %0d required 16", lat); end
    total++;
    if (bc !== 16) begin bad++; $display("FAIL ovf_busy_cycles: got %0d required 16", bc); end
    total++;
    if (bus64.busy !== 1'b0) begin bad++; $display("FAIL ovf_busy_at_done: got %b required 0", bus64.busy); end
    total++;
    if (bus64.s !== 64'h8000_0000_0000_0000) begin
      bad++; $display("FAIL ovf_s: got %h required 8000000000000000", bus64.s);
    end
    total++;
    if ({bus64.co, bus64.co_prev, bus64.ov, bus64.zero, bus64.neg} !== 5'b01101) begin
      bad++; $display("FAIL ovf_flags co,cp,ov,z,n: got %b required 01101",
                      {bus64.co, bus64.co_prev, bus64.ov, bus64.zero, bus64.neg});
    end
    @(posedge clk); #1;
    total++;
    if (bus64.done !== 1'b0) begin bad++; $display("FAIL ovf_done_pulse: got %b required 0", bus64.done); end
  endtask

  task automatic test_wrap;
    int lat, bc;
    go64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat, bc);
    total++;
    if (bus64.s !== 64'h0) begin bad++; $display("FAIL wrap_s: got %h required 0", bus64.s); end
    total++;
    if ({bus64.co, bus64.co_prev, bus64.ov, bus64.zero, bus64.neg} !== 5'b11010) begin
      bad++; $display("FAIL wrap_flags co,cp,ov,z,n: got %b required 11010",
                      {bus64.co, bus64.co_prev, bus64.ov, bus64.zero, bus64.neg});
    end
  endtask

  task automatic test_sub;
    logic [63:0] va[3], vb[3], vs[3];
    logic        vc[3];
    logic [4:0]  vf[3];
    int lat, bc;
    // 5-7 ; 0x8000..-1 ; 10-3-1   flags = co,co_prev,ov,zero,neg
    va[0] = 64'd5;                  vb[0] = 64'd7; vc[0] = 1'b0;
    vs[0] = 64'hFFFF_FFFF_FFFF_FFFE; vf[0] = 5'b00001;
    va[1] = 64'h8000_0000_0000_0000; vb[1] = 64'd1; vc[1] = 1'b0;
    vs[1] = 64'h7FFF_FFFF_FFFF_FFFF; vf[1] = 5'b10100;
    va[2] = 64'd10;                 vb[2] = 64'd3; vc[2] = 1'b1;
    vs[2] = 64'd6;                  vf[2] = 5'b11000;
    for (int i = 0; i < 3; i++) begin
      go64(1'b1, va[i], vb[i], vc[i], lat, bc);
      total++;
      if (bus64.s !== vs[i]) begin
        bad++; $display("FAIL sub%0d_s: got %h required %h", i, bus64.s, vs[i]);
      end
      total++;
      if ({bus64.co, bus64.co_prev, bus64.ov, bus64.zero, bus64.neg} !== vf[i]) begin
        bad++; $display("FAIL sub%0d_flags co,cp,ov,z,n: got %b required %b", i,
                        {bus64.co, bus64.co_prev, bus64.ov, bus64.zero, bus64.neg}, vf[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cnt;
    @(posedge clk); #1;
    bus64.op = 0; bus64.a = 64'd1; bus64.b = 64'd2; bus64.ci = 0; bus64.start = 1'b1;
    @(posedge clk); #1;                 // E0
    bus64.start = 1'b0;
    repeat (5) @(posedge clk); #1;      // after E5
    bus64.op = 1; bus64.a = 64'hDEAD; bus64.b = 64'h1; bus64.ci = 1; bus64.start = 1'b1;
    @(posedge clk); #1;                 // after E6, pulse ignored
    bus64.start = 1'b0;
    repeat (4) @(posedge clk); #1;      // after E10
    bus64.op = 0; bus64.a = 64'd100; bus64.b = 64'd23; bus64.ci = 1; bus64.start = 1'b1;
    cnt = 10;
    while (bus64.done !== 1'b1 && cnt < 100) begin @(posedge clk); #1; cnt++; end
    total++;
    if (cnt !== 16) begin bad++; $display("FAIL b2b_first_latency: got %0d required 16", cnt); end
    total++;
    if (bus64.s !== 64'd3) begin bad++; $display("FAIL b2b_first_s: got %h required 3", bus64.s); end
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) begin
        bus64.start = 1'b0;
        total++;
        if (bus64.busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy: got %b required 1", bus64.busy); end
      end
    end while (bus64.done !== 1'b1 && cnt < 100);
    total++;
    if (cnt !== 17) begin bad++; $display("FAIL b2b_done_spacing: got %0d required 17", cnt); end
    total++;
    if (bus64.s !== 64'd124) begin bad++; $display("FAIL b2b_second_s: got %h required 7c", bus64.s); end
  endtask

  task automatic test_midrun_reset;
    int lat, bc;
    bit saw_done;
    @(posedge clk); #1;
    bus64.op = 0; bus64.a = 64'h5555; bus64.b = 64'h1; bus64.ci = 0; bus64.start = 1'b1;
    @(posedge clk); #1;
    bus64.start = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;                    // between edges, RUN cycle 8
    #1;
    total++;
    if ({bus64.busy, bus64.done, bus64.co, bus64.ov, bus64.zero, bus64.neg} !== 6'b0) begin
      bad++; $display("FAIL midrst_flags: got %b required 0",
                      {bus64.busy, bus64.done, bus64.co, bus64.ov, bus64.zero, bus64.neg});
    end
    total++;
    if (bus64.s !== 64'h0) begin bad++; $display("FAIL midrst_s: got %h required 0", bus64.s); end
    @(negedge clk) reset = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus64.done === 1'b1) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin bad++; $display("FAIL midrst_no_done: got %b required 0", saw_done); end
    go64(1'b0, 64'h1234, 64'h1, 1'b0, lat, bc);
    total++;
    if (lat !== 16) begin bad++; $display("FAIL midrst_restart_latency: got %0d required 16", lat); end
    total++;
    if (bus64.s !== 64'h1235) begin bad++; $display("FAIL midrst_restart_s: got %h required 1235", bus64.s); end
  endtask

  task automatic test_w32;
    int lat;
    @(posedge clk); #1;
    bus32.op = 0; bus32.a = 32'h7FFF_FFFF; bus32.b = 32'h1; bus32.ci = 0; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (bus32.done !== 1'b1 && lat < 100);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL w32_latency: got %0d required 4", lat); end
    total++;
    if (bus32.s !== 32'h8000_0000) begin bad++; $display("FAIL w32_s: got %h required 80000000", bus32.s); end
    total++;
    if ({bus32.co, bus32.co_prev, bus32.ov, bus32.zero, bus32.neg} !== 5'b01101) begin
      bad++; $display("FAIL w32_flags co,cp,ov,z,n: got %b required 01101",
                      {bus32.co, bus32.co_prev, bus32.ov, bus32.zero, bus32.neg});
    end
  endtask

  task automatic test_w8_sweep;
    logic [7:0]  be;
    logic        c0;
    logic [8:0]  full;
    logic [7:0]  low;
    logic [13:0] exp_v, got_v;
    @(posedge clk); #1;
    for (int o = 0; o < 2; o++)
      for (int ai = 0; ai < 256; ai += 3)
        for (int bi = 0; bi < 256; bi += 5)
          for (int c = 0; c < 2; c++) begin
            bus8.op = o[0]; bus8.a = ai[7:0]; bus8.b = bi[7:0]; bus8.ci = c[0];
            bus8.start = 1'b1;
            @(posedge clk); #1;
            bus8.start = 1'b0;
            @(posedge clk); #1;
            be    = o[0] ? ~bi[7:0] : bi[7:0];
            c0    = c[0] ^ o[0];
            full  = {1'b0, ai[7:0]} + {1'b0, be} + {8'b0, c0};
            low   = {1'b0, ai[6:0]} + {1'b0, be[6:0]} + {7'b0, c0};
            exp_v = {1'b1, full[7:0], full[8], low[7], full[8] ^ low[7], full[7:0] == 8'h0, full[7]};
            got_v = {bus8.done, bus8.s, bus8.co, bus8.co_prev, bus8.ov, bus8.zero, bus8.neg};
            total++;
            if (got_v !== exp_v) begin
              bad++;
              $display("FAIL w8 op=%0d a=%0d b=%0d ci=%0d done,s,co,cp,ov,z,n: got %b required %b",
                       o, ai, bi, c, got_v, exp_v);
            end
          end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_wrap();
    test_sub();
    test_back_to_back();
    test_midrun_reset();
    test_w32();
    test_w8_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
